vm_result_writer: RTL and testbench
===================================

// Module: vm_result_writer
// PURPOSE
//  Downstream stage of the vector-multiply wrapper: accepts each dot-product result and
//  writes it back to the data memory through its write port (we/wr_addr/wr_data).
//  The result (RW bits) is wider than a memory word (DW bits), so each result is split
//  into BEATS words, LSB first, at consecutive addresses starting at BASE_ADDR.
//  Stops after NUM_RESULTS results and flags done; restarted by a start pulse.
// PARAMETERS
//  DW           4    memory word width; element width of the multiplier
//  N            4    elements per vector; sets result width
//  AW           5    memory address width ($clog2 of memory depth 32)
//  BASE_ADDR    16   first write address
//  NUM_RESULTS  4    results written per run (>=1)
//  derived: RW = 2*DW + $clog2(N) (10); BEATS = ceil(RW/DW) (3)
// PORTS
//  clk           in   1    rising-edge clock
//  rst           in   1    asynchronous, active-low reset
//  start         in   1    1-cycle pulse: begin a new run
//  result        in   RW   result from the vector-multiply wrapper
//  result_valid  in   1    result holds a new value
//  result_ready  out  1    writer accepts result this cycle
//  mem_wr_en     out  1    memory write enable
//  wr_addr       out  AW   memory write address
//  wr_data       out  DW   memory write data
//  busy          out  1    run in progress (not IDLE/DONE)
//  done          out  1    run complete; held until next start
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; result_ready=0, mem_wr_en=0, wr_addr=BASE_ADDR,
//    wr_data=0, busy=0, done=0; result count=0, beat count=0, hold register=0.
//  - States: IDLE -> ACCEPT on start. ACCEPT -> WRITE on result_valid&result_ready
//    (result captured in hold register). WRITE -> ACCEPT after last beat if count<NUM_RESULTS,
//    else -> DONE (or STATUS, see CONFIGURATION). DONE -> ACCEPT on start.
//  - result_ready = 1 only in ACCEPT (registered state decode, no comb path from valid).
//  - Beat k (k=0..BEATS-1) = hold[k*DW +: DW]; bits above RW in last beat are zero.
//  - Latency: first beat mem_wr_en=1 on the cycle after acceptance; beats on consecutive
//    cycles; result_ready reasserts the cycle after the last beat. Throughput: one result
//    per BEATS+1 cycles.
//  - wr_addr increments by 1 after every written beat; wraps modulo 2^AW (31 -> 0), no flag.
//  - mem_wr_en, wr_addr, wr_data are registered; wr_data/wr_addr hold last value when idle.
//  - result count increments at acceptance; done asserts the cycle after the final beat.
//  - start in any state (incl. mid-WRITE): in-flight beats aborted (no further writes),
//    counts cleared, wr_addr=BASE_ADDR, done=0, next state ACCEPT. start has priority
//    over an acceptance in the same cycle (that result is not taken).
//  - result_valid in IDLE/DONE ignored; result_ready stays 0.
//  - rst asserted mid-run: immediate return to reset values; partial writes not completed.
// CONFIGURATION
//  VM_WB_STATUS_EN defined: after the last result's final beat, state STATUS writes one
//    extra word at the next address: wr_data = NUM_RESULTS[DW-1:0]; done asserts the
//    cycle after that write. Not defined: STATUS absent, no extra write, WRITE -> DONE.
// TESTING (DW=4, N=4, AW=5, BASE_ADDR=16, NUM_RESULTS=4 unless noted)
//  1 reset release, no start, result_valid=1 -> result_ready=0, mem_wr_en=0, done=0, busy=0.
//  2 start, result=10'h2A5 valid -> writes 5@16, A@17, 2@18 on 3 consecutive cycles;
//    result_ready low 3 cycles, high again on 4th.
//  3 four results 0x001,0x3FF,0x123,0x0F0 held valid -> 12 writes at 16..27, done=1 after
//    last; further result_valid ignored; with VM_WB_STATUS_EN extra write 4@28 then done.
//  4 BASE_ADDR=30, one result 10'h155 -> writes 5@30, 5@31, 1@0 (address wrap).
//  5 start pulse during beat 2 of a result -> no write on next cycle, wr_addr back to 16,
//    next accepted result written at 16..18, done=0 until 4 new results.
//  6 rst pulsed low mid-WRITE -> all outputs at reset values in the same cycle, no writes
//    until next start.

Source files
------------

// File: rtl/vm_result_writer.sv
// vm_result_writer
//   Write-back stage of the vector-multiply wrapper. Each accepted dot-product
//   result (RW bits) is split into BEATS memory words (DW bits), LSB first,
//   and written to consecutive addresses starting at BASE_ADDR. After
//   NUM_RESULTS results the block parks in DONE until the next start pulse.
//
//   Optional feature macro: VM_WB_STATUS_EN
//     When defined, one extra status word (NUM_RESULTS truncated to DW bits)
//     is written at the next address after the final beat, before DONE.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         1-cycle pulse, (re)starts a run from any state
//   result        dot-product result, RW bits
//   result_valid  result holds a new value
//   result_ready  high only in ACCEPT (pure state decode)
//   mem_wr_en     registered memory write enable
//   wr_addr       registered write address, wraps modulo 2^AW
//   wr_data       registered write data, holds last value when not writing
//   busy          run in progress (ACCEPT/WRITE/STATUS)
//   done          run complete, held until next start
module vm_result_writer #(
  parameter int DW          = 4,
  parameter int N           = 4,
  parameter int AW          = 5,
  parameter int BASE_ADDR   = 16,
  parameter int NUM_RESULTS = 4,
  localparam int RW         = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] result,
  input  logic          result_valid,
  output logic          result_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  localparam int BEATS = (RW + DW - 1) / DW;
  localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(NUM_RESULTS + 1);

  localparam logic [AW-1:0]  BASE      = AW'(BASE_ADDR);
  localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);
  localparam logic [CW-1:0]  LAST_RES  = CW'(NUM_RESULTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
`ifdef VM_WB_STATUS_EN
    S_STATUS,
`endif
    S_DONE
  } state_t;

  typedef logic [BEATS-1:0][DW-1:0] beats_t;

  state_t                state, state_nxt;
  beats_t                hold, hold_nxt;
  logic [BEATS*DW-1:0]   res_ext;
  logic [BIW-1:0]        beat_cnt, beat_nxt, beat_inc;
  logic [CW-1:0]         res_cnt, res_nxt;
  logic                  wen_nxt;
  logic [AW-1:0]         addr_nxt;
  logic [DW-1:0]         data_nxt;

  assign result_ready = (state == S_ACCEPT);
  assign busy         = (state != S_IDLE) && (state != S_DONE);
  assign done         = (state == S_DONE);

  // Zero-extend so bits above RW in the last beat read as zero.
  assign res_ext  = (BEATS*DW)'(result);
  assign beat_inc = beat_cnt + 1'b1;

  // beat_cnt is the index of the beat currently on wr_data; wr_addr is its
  // address and advances on the edge that ends that write. Beat 0 is taken
  // straight from the input at acceptance so it lands the following cycle.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    beat_nxt  = beat_cnt;
    res_nxt   = res_cnt;
    wen_nxt   = 1'b0;
    addr_nxt  = wr_addr;
    data_nxt  = wr_data;
    if (start) begin
      // Start wins over everything, including a same-cycle acceptance.
      state_nxt = S_ACCEPT;
      beat_nxt  = '0;
      res_nxt   = '0;
      addr_nxt  = BASE;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (result_valid) begin
            hold_nxt  = res_ext;
            wen_nxt   = 1'b1;
            data_nxt  = result[DW-1:0];
            beat_nxt  = '0;
            res_nxt   = res_cnt + 1'b1;
            state_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          addr_nxt = wr_addr + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            if (res_cnt == LAST_RES) begin
`ifdef VM_WB_STATUS_EN
              wen_nxt   = 1'b1;
              data_nxt  = DW'(NUM_RESULTS);
              state_nxt = S_STATUS;
`else
              state_nxt = S_DONE;
`endif
            end else begin
              state_nxt = S_ACCEPT;
            end
          end else begin
            beat_nxt = beat_inc;
            wen_nxt  = 1'b1;
            data_nxt = hold[beat_inc];
          end
        end
`ifdef VM_WB_STATUS_EN
        S_STATUS: begin
          addr_nxt  = wr_addr + 1'b1;
          state_nxt = S_DONE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      beat_cnt  <= '0;
      res_cnt   <= '0;
      mem_wr_en <= 1'b0;
      wr_addr   <= BASE;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      beat_cnt  <= beat_nxt;
      res_cnt   <= res_nxt;
      mem_wr_en <= wen_nxt;
      wr_addr   <= addr_nxt;
      wr_data   <= data_nxt;
    end
  end

endmodule

// File: tb/tb_vm_result_writer.sv
// Directed bench for vm_result_writer. Main instance uses the default
// parameters; a second instance (BASE_ADDR=30, NUM_RESULTS=1) covers the
// address wrap. Observed outputs are packed as
// {result_ready, mem_wr_en, busy, done, wr_addr[4:0], wr_data[3:0]}.
module tb_vm_result_writer;
  localparam int RW = 10;
  typedef logic [12:0] ob_t;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic          rst, start, result_valid;
  logic [RW-1:0] result;
  logic          result_ready, mem_wr_en, busy, done;
  logic [4:0]    wr_addr;
  logic [3:0]    wr_data;

  logic          start2, valid2;
  logic [RW-1:0] result2;
  logic          ready2, wen2, busy2, done2;
  logic [4:0]    addr2;
  logic [3:0]    data2;

  int total = 0;
  int bad   = 0;

  vm_result_writer dut (
    .clk(tb_clk), .rst(rst), .start(start), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .mem_wr_en(mem_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  vm_result_writer #(.BASE_ADDR(30), .NUM_RESULTS(1)) dut2 (
    .clk(tb_clk), .rst(rst), .start(start2), .result(result2),
    .result_valid(valid2), .result_ready(ready2),
    .mem_wr_en(wen2), .wr_addr(addr2), .wr_data(data2),
    .busy(busy2), .done(done2)
  );

  function automatic ob_t pk(logic rdy, logic we, logic bsy, logic dn,
                             logic [4:0] a, logic [3:0] d);
    return {rdy, we, bsy, dn, a, d};
  endfunction

  function automatic ob_t ob1();
    return {result_ready, mem_wr_en, busy, done, wr_addr, wr_data};
  endfunction

  function automatic ob_t ob2();
    return {ready2, wen2, busy2, done2, addr2, data2};
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic test_reset();
    ob_t e;
    rst = 1'b0; start = 1'b0; result_valid = 1'b1; result = 10'h3FF;
    start2 = 1'b0; valid2 = 1'b0; result2 = '0;
    repeat (2) tick();
    e = pk(0, 0, 0, 0, 5'd16, 4'h0);
    total++; if (ob1() !== e) begin bad++; $display("FAIL reset_hold got=%h want=%h", ob1(), e); end
    e = pk(0, 0, 0, 0, 5'd30, 4'h0);
    total++; if (ob2() !== e) begin bad++; $display("FAIL reset_dut2 got=%h want=%h", ob2(), e); end
    rst = 1'b1;
    e = pk(0, 0, 0, 0, 5'd16, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ob1() !== e) begin bad++; $display("FAIL reset_idle[%0d] got=%h want=%h", i, ob1(), e); end
    end
    result_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] d [3] = '{4'h5, 4'hA, 4'h2};
    ob_t e;
    start = 1'b1; tick(); start = 1'b0;
    e = pk(1, 0, 1, 0, 5'd16, 4'h0);
    total++; if (ob1() !== e) begin bad++; $display("FAIL single_accept got=%h want=%h", ob1(), e); end
    result = 10'h2A5; result_valid = 1'b1; tick(); result_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = pk(0, 1, 1, 0, 5'(16 + k), d[k]);
      total++; if (ob1() !== e) begin bad++; $display("FAIL single_beat[%0d] got=%h want=%h", k, ob1(), e); end
      tick();
    end
    e = pk(1, 0, 1, 0, 5'd19, 4'h2);
    total++; if (ob1() !== e) begin bad++; $display("FAIL single_rdy got=%h want=%h", ob1(), e); end
  endtask

  task automatic test_full_run();
    logic [RW-1:0] vals [4] = '{10'h001, 10'h3FF, 10'h123, 10'h0F0};
    logic [3:0] ex [12] = '{4'h1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h3,
                            4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'h0};
    ob_t e;
    start = 1'b1; tick(); start = 1'b0;
    e = pk(1, 0, 1, 0, 5'd16, 4'h2);
    total++; if (ob1() !== e) begin bad++; $display("FAIL run_start got=%h want=%h", ob1(), e); end
    result_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      result = vals[r];
      tick();
      for (int k = 0; k < 3; k++) begin
        e = pk(0, 1, 1, 0, 5'(16 + 3*r + k), ex[3*r + k]);
        total++; if (ob1() !== e) begin bad++; $display("FAIL run_beat[%0d] got=%h want=%h", 3*r + k, ob1(), e); end
        tick();
      end
      if (r < 3) begin
        e = pk(1, 0, 1, 0, 5'(19 + 3*r), ex[3*r + 2]);
        total++; if (ob1() !== e) begin bad++; $display("FAIL run_rdy[%0d] got=%h want=%h", r, ob1(), e); end
      end
    end
`ifdef VM_WB_STATUS_EN
    e = pk(0, 1, 1, 0, 5'd28, 4'h4);
    total++; if (ob1() !== e) begin bad++; $display("FAIL run_status got=%h want=%h", ob1(), e); end
    tick();
    e = pk(0, 0, 0, 1, 5'd29, 4'h4);
`else
    e = pk(0, 0, 0, 1, 5'd28, 4'h0);
`endif
    total++; if (ob1() !== e) begin bad++; $display("FAIL run_done got=%h want=%h", ob1(), e); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ob1() !== e) begin bad++; $display("FAIL done_hold[%0d] got=%h want=%h", i, ob1(), e); end
    end
    result_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [4:0] a [3] = '{5'd30, 5'd31, 5'd0};
    logic [3:0] d [3] = '{4'h5, 4'h5, 4'h1};
    ob_t e;
    start2 = 1'b1; tick(); start2 = 1'b0;
    result2 = 10'h155; valid2 = 1'b1; tick(); valid2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = pk(0, 1, 1, 0, a[k], d[k]);
      total++; if (ob2() !== e) begin bad++; $display("FAIL wrap_beat[%0d] got=%h want=%h", k, ob2(), e); end
      tick();
    end
`ifdef VM_WB_STATUS_EN
    e = pk(0, 1, 1, 0, 5'd1, 4'h1);
    total++; if (ob2() !== e) begin bad++; $display("FAIL wrap_status got=%h want=%h", ob2(), e); end
    tick();
    e = pk(0, 0, 0, 1, 5'd2, 4'h1);
`else
    e = pk(0, 0, 0, 1, 5'd1, 4'h1);
`endif
    total++; if (ob2() !== e) begin bad++; $display("FAIL wrap_done got=%h want=%h", ob2(), e); end
  endtask

  task automatic test_restart();
    logic [3:0] d [3] = '{4'h0, 4'hF, 4'h0};
    ob_t e;
    start = 1'b1; tick(); start = 1'b0;
    result = 10'h2A5; result_valid = 1'b1; tick(); result_valid = 1'b0;
    e = pk(0, 1, 1, 0, 5'd16, 4'h5);
    total++; if (ob1() !== e) begin bad++; $display("FAIL abort_beat0 got=%h want=%h", ob1(), e); end
    tick();
    e = pk(0, 1, 1, 0, 5'd17, 4'hA);
    total++; if (ob1() !== e) begin bad++; $display("FAIL abort_beat1 got=%h want=%h", ob1(), e); end
    start = 1'b1; tick(); start = 1'b0;
    e = pk(1, 0, 1, 0, 5'd16, 4'hA);
    total++; if (ob1() !== e) begin bad++; $display("FAIL abort_restart got=%h want=%h", ob1(), e); end
    // start and a valid result in the same ACCEPT cycle: the result is dropped
    result = 10'h3FF; result_valid = 1'b1; start = 1'b1; tick(); start = 1'b0;
    total++; if (ob1() !== e) begin bad++; $display("FAIL start_priority got=%h want=%h", ob1(), e); end
    result = 10'h0F0; tick(); result_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = pk(0, 1, 1, 0, 5'(16 + k), d[k]);
      total++; if (ob1() !== e) begin bad++; $display("FAIL restart_beat[%0d] got=%h want=%h", k, ob1(), e); end
      tick();
    end
    e = pk(1, 0, 1, 0, 5'd19, 4'h0);
    total++; if (ob1() !== e) begin bad++; $display("FAIL restart_not_done got=%h want=%h", ob1(), e); end
  endtask

  task automatic test_reset_mid();
    ob_t e;
    result = 10'h123; result_valid = 1'b1; tick(); result_valid = 1'b0;
    e = pk(0, 1, 1, 0, 5'd19, 4'h3);
    total++; if (ob1() !== e) begin bad++; $display("FAIL mid_beat0 got=%h want=%h", ob1(), e); end
    tick();
    e = pk(0, 1, 1, 0, 5'd20, 4'h2);
    total++; if (ob1() !== e) begin bad++; $display("FAIL mid_beat1 got=%h want=%h", ob1(), e); end
    rst = 1'b0; #1;
    e = pk(0, 0, 0, 0, 5'd16, 4'h0);
    total++; if (ob1() !== e) begin bad++; $display("FAIL reset_async got=%h want=%h", ob1(), e); end
    tick();
    total++; if (ob1() !== e) begin bad++; $display("FAIL reset_low got=%h want=%h", ob1(), e); end
    rst = 1'b1; result_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ob1() !== e) begin bad++; $display("FAIL reset_no_write[%0d] got=%h want=%h", i, ob1(), e); end
    end
    result_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_run();
    test_wrap();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
